icache_fetch_ctrl: RTL

// - Stage-one instruction fetch front end. Sits between the program counter/IMAR and the 256x16 instruction RAM, and delivers words to the IR.
// - Direct-mapped instruction cache of 4 one-word lines; a miss runs a read cycle on the instruction RAM and refills the line.
// - Stalls the fetch stage through a req/ack handshake until the word is available.

---
 rtl/icache_fetch_ctrl_pkg.sv | 20 ++
 rtl/icache_line_array.sv | 61 ++++++
 rtl/icache_fetch_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/icache_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_fetch_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 2;
    localparam int LINES  = 1 << IDX_W;
    localparam int TAG_W  = ADDR_W - IDX_W;

    // The fetch path only ever reads the instruction RAM.
    localparam logic RAM_RD = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache lines.
// Latency: combinational read; writes and flush take effect on the next edge.
// Backpressure: none; flush overrides a same-cycle write of the valid bit.
module icache_line_array
    import icache_fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid
);

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [TAG_W-1:0]  tag_d  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [DATA_W-1:0] data_d [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    // Next line contents: refill write first, then flush wipes every valid bit.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Line storage registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Fetch front end: 4-line direct-mapped I-cache with RAM refill on miss.
// Latency: hit 1 cycle req->ack; miss RAM_LAT+1 cycles req->ack.
// Backpressure: requester holds req/addr until the one-cycle ack pulse.
module icache_fetch_ctrl
    import icache_fetch_ctrl_pkg::*;
#(
    parameter int RAM_LAT = 2
)
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic              ack,
    output logic [DATA_W-1:0] instr,
    output logic              hit,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ce,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        miss_cnt
);

    localparam int              CNT_W    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LAT - 1);

    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [7:0]        miss_cnt_q, miss_cnt_d;
    logic              ack_q, ack_d;
    logic              hit_q, hit_d;
    logic              flushed_q, flushed_d;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              wr_valid;
    logic              lookup_hit;
    logic              fill_last;

    // A flush in the lookup cycle forces the miss path.
    assign lookup_hit = req && !flush && rd_valid && (rd_tag == addr[ADDR_W-1:IDX_W]);
    assign fill_last  = (state_q == ST_FILL) && (cnt_q == CNT_LAST);

    icache_line_array u_lines (
        .clk      (clk),
        .clr_n    (clr_n),
        .rd_idx   (addr[IDX_W-1:0]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_idx   (ram_addr_q[IDX_W-1:0]),
        .wr_tag   (ram_addr_q[ADDR_W-1:IDX_W]),
        .wr_data  (ram_rdata),
        .wr_valid (wr_valid)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a missing request starts a refill, the last wait cycle ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req && !lookup_hit) state_d = ST_FILL;
            ST_FILL: if (fill_last)          state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: ack/hit/instr, refill address, wait counter, miss count.
    always_comb begin
        ack_d      = 1'b0;
        hit_d      = 1'b0;
        instr_d    = instr_q;
        ram_addr_d = ram_addr_q;
        cnt_d      = cnt_q;
        miss_cnt_d = miss_cnt_q;
        flushed_d  = flushed_q;
        wr_en      = 1'b0;
        wr_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lookup_hit) begin
                    ack_d   = 1'b1;
                    hit_d   = 1'b1;
                    instr_d = rd_data;
                end else if (req) begin
                    ram_addr_d = addr;
                    cnt_d      = '0;
                    flushed_d  = 1'b0;
                    miss_cnt_d = (miss_cnt_q == 8'hFF) ? miss_cnt_q : miss_cnt_q + 8'd1;
                end
            end
            ST_FILL: begin
                // Remember any flush seen while the RAM read is in flight.
                flushed_d = flushed_q | flush;
                if (fill_last) begin
                    wr_en    = 1'b1;
                    wr_valid = !(flushed_q || flush);
                    // A requester that walked away gets no ack, and instr keeps its old word.
                    if (req) begin
                        ack_d   = 1'b1;
                        instr_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ack_q      <= 1'b0;
            hit_q      <= 1'b0;
            instr_q    <= '0;
            ram_addr_q <= '0;
            cnt_q      <= '0;
            miss_cnt_q <= '0;
            flushed_q  <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            hit_q      <= hit_d;
            instr_q    <= instr_d;
            ram_addr_q <= ram_addr_d;
            cnt_q      <= cnt_d;
            miss_cnt_q <= miss_cnt_d;
            flushed_q  <= flushed_d;
        end
    end

    assign ack      = ack_q;
    assign hit      = hit_q;
    assign instr    = instr_q;
    assign ram_addr = ram_addr_q;
    assign ram_ce   = (state_q == ST_FILL);
    assign busy     = (state_q == ST_FILL);
    assign ram_rw   = RAM_RD;
    assign miss_cnt = miss_cnt_q;

endmodule
